id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  Parametrised ID->EX pipeline register; successor to the fixed 32-bit latch-every-clock stage.
//  Adds reset, valid/ready handshake, optional 1-entry skid buffer, flush, and bubble insertion.
//  Sits between decode (control unit, register file, sign extender) and execute (ALU, fwd mux).
//  Stalls from hazard logic or EX back-pressure never drop or duplicate an instruction.
// PARAMETERS
//  DATA_W   32  width of pc_plus4, rs_val, rt_val, imm_ext
//  RADDR_W  5   register-specifier width (rs/rt/rd fields)
//  ALUOP_W  2   ALUOp width
//  SKID     1   1 = skid entry present (in_ready registered); 0 = in_ready = !out_valid | out_ready
// PORTS
//  clk         in   1        rising-edge clock (single clock domain)
//  rst         in   1        synchronous, active-high reset
//  flush       in   1        kill every held entry and this cycle's input (branch taken / exception)
//  in_valid    in   1        ID presents a valid instruction
//  in_ready    out  1        stage accepts this cycle
//  in_ctrl     in   8+ALUOP_W-1  {RegWrite,MemtoReg,Branch,MemRead,MemWrite,RegDst,ALUSrc,ALUOp}
//  in_pc4      in   DATA_W   PC+4 of instruction
//  in_rs_val   in   DATA_W   register file read port 1
//  in_rt_val   in   DATA_W   register file read port 2
//  in_imm      in   DATA_W   sign-extended immediate
//  in_rs/in_rt/in_rd in RADDR_W  instr[25:21], [20:16], [15:11]
//  out_valid   out  1        EX slot holds a live instruction
//  out_ready   in   1        EX consumes this cycle
//  out_*       out  (same)   registered copies of every in_* field
// BEHAVIOUR
//  - Reset (rst=1 at posedge): out_valid=0, skid empty, every out_* field = 0, in_ready=1 next cycle.
//  - Transfer in: in_valid & in_ready; transfer out: out_valid & out_ready. Zero-bubble streaming:
//    main register loads when !out_valid | out_ready; latency in->out exactly 1 cycle when unstalled.
//  - SKID=1: if input accepted while main held (out_valid & !out_ready), beat goes to skid entry;
//    in_ready = !skid_valid (registered, no comb path from out_ready). Next out-transfer moves skid->main
//    and clears skid_valid; order strictly preserved (skid is always younger than main).
//  - SKID=0: in_ready = !out_valid | out_ready (comb); no skid storage.
//  - Bubble: whenever out_valid=0, out RegWrite/MemRead/MemWrite/Branch forced 0 (data fields keep last).
//  - flush=1: next cycle out_valid=0, skid empty; input in same cycle discarded even if in_valid&in_ready.
//    flush has priority over every transfer; rst has priority over flush.
//  - in_valid must hold with stable payload until accepted; stage never drops an accepted beat.
//  - Reset mid-stall: held beats lost by design; ID re-fetches.
//  - No arithmetic; all fields passed bit-exact; widths set by parameters only.
// STRUCTURE
//  - Shared include mips_pipe_defs.vh: control-bit index constants (CTL_REGWRITE..CTL_ALUOP),
//    CTL_W, default widths.
//  - One sub-module: pipe_skid_buf #(W, SKID) - generic valid/ready register + skid; payload
//    = concatenated control+data vector. Top adds bubble masking only. Reused later for EX/MEM, MEM/WB.
// TESTING
//  1 rst 2 cycles -> out_valid=0, all out_* 0, in_ready=1; first beat pc4=0x4 appears next cycle.
//  2 stream 8 beats, out_ready=1 -> out sequence identical, 1-cycle latency, no gaps.
//  3 SKID=1: out_ready=0 with beats A,B offered -> A held, B in skid, in_ready=0; release -> A then B, then C.
//  4 flush with A held, B in skid, C offered -> next cycle out_valid=0, RegWrite/MemWrite=0, C never emerges.
//  5 in_valid=0 gap -> out_valid=0, out MemWrite/RegWrite/MemRead/Branch=0 regardless of in_ctrl.
//  6 random valid/ready/flush, both SKID values, DATA_W=64 -> scoreboard: no loss, dup or reorder.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared constants for the ID->EX pipeline register.
// Control-bit offsets are counted from the bit just above ALUOp.
package id_ex_stage_reg_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int RADDR_W_DEF = 5;
    localparam int ALUOP_W_DEF = 2;

    // Single-bit control flags stacked above ALUOp
    localparam int CTL_FLAGS   = 7;
    localparam int CTL_ALUSRC   = 0;
    localparam int CTL_REGDST   = 1;
    localparam int CTL_MEMWRITE = 2;
    localparam int CTL_MEMREAD  = 3;
    localparam int CTL_BRANCH   = 4;
    localparam int CTL_MEMTOREG = 5;
    localparam int CTL_REGWRITE = 6;

    function automatic int ctl_w(input int aluop_w);
        return CTL_FLAGS + aluop_w;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_skid.sv
// Generic valid/ready pipeline register with an optional one-entry skid.
// Reused for the later EX/MEM and MEM/WB stages.
module pipe_skid_buf #(
    parameter int W    = 32,
    parameter int SKID = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_v;
    logic [W-1:0] main_d;
    logic         skid_v;
    logic [W-1:0] skid_d;
    logic         load_main;
    logic         in_fire;

    assign load_main = !main_v || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = main_v;
    assign out_data  = main_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v <= 1'b0;
            main_d <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
        end else if (load_main) begin
            // Skid is always the older waiting beat, so it drains first
            if (skid_v) begin
                main_v <= 1'b1;
                main_d <= skid_d;
            end else begin
                main_v <= in_fire;
                if (in_fire)
                    main_d <= in_data;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = !skid_v;

            always_ff @(posedge clk) begin
                if (rst) begin
                    skid_v <= 1'b0;
                    skid_d <= '0;
                end else if (flush) begin
                    skid_v <= 1'b0;
                end else if (load_main) begin
                    skid_v <= 1'b0;
                end else if (in_fire) begin
                    skid_v <= 1'b1;
                    skid_d <= in_data;
                end
            end
        end else begin : g_noskid
            assign in_ready = load_main;
            assign skid_v   = 1'b0;
            assign skid_d   = '0;
        end
    endgenerate

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register: handshake, optional skid, flush, bubble masking.
// Bubbles force the side-effecting control bits low so EX/MEM never act on stale data.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int SKID    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTL_FLAGS+ALUOP_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0]            in_pc4,
    input  logic [DATA_W-1:0]            in_rs_val,
    input  logic [DATA_W-1:0]            in_rt_val,
    input  logic [DATA_W-1:0]            in_imm,
    input  logic [RADDR_W-1:0]           in_rs,
    input  logic [RADDR_W-1:0]           in_rt,
    input  logic [RADDR_W-1:0]           in_rd,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTL_FLAGS+ALUOP_W-1:0] out_ctrl,
    output logic [DATA_W-1:0]            out_pc4,
    output logic [DATA_W-1:0]            out_rs_val,
    output logic [DATA_W-1:0]            out_rt_val,
    output logic [DATA_W-1:0]            out_imm,
    output logic [RADDR_W-1:0]           out_rs,
    output logic [RADDR_W-1:0]           out_rt,
    output logic [RADDR_W-1:0]           out_rd
);

    localparam int CTL_W = ctl_w(ALUOP_W);
    localparam int W     = CTL_W + 4 * DATA_W + 3 * RADDR_W;

    logic [W-1:0]     in_pay;
    logic [W-1:0]     out_pay;
    logic [CTL_W-1:0] ctrl_raw;
    logic [CTL_W-1:0] kill;

    assign in_pay = {in_ctrl, in_pc4, in_rs_val, in_rt_val,
                     in_imm, in_rs, in_rt, in_rd};

    pipe_skid_buf #(
        .W    (W),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pay)
    );

    assign {ctrl_raw, out_pc4, out_rs_val, out_rt_val,
            out_imm, out_rs, out_rt, out_rd} = out_pay;

    always_comb begin
        kill = '0;
        kill[ALUOP_W + CTL_REGWRITE] = 1'b1;
        kill[ALUOP_W + CTL_BRANCH]   = 1'b1;
        kill[ALUOP_W + CTL_MEMREAD]  = 1'b1;
        kill[ALUOP_W + CTL_MEMWRITE] = 1'b1;
    end

    assign out_ctrl = out_valid ? ctrl_raw : (ctrl_raw & ~kill);

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench: u0 has the skid entry, u1 does not; both run DATA_W=64.
// The reference model is an ordered queue of accepted beats per instance.
module tb_id_ex_stage_reg;

    localparam int DW = 64;
    localparam int RW = 5;
    localparam int AW = 2;
    localparam int CW = 9;
    // {RegWrite,MemtoReg,Branch,MemRead,MemWrite,RegDst,ALUSrc,ALUOp[1:0]}
    localparam logic [CW-1:0] KILL = 9'b1_0111_0000;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] pc4;
        logic [DW-1:0] rs_val;
        logic [DW-1:0] rt_val;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    logic in_valid [2];
    logic in_ready [2];
    logic out_valid [2];
    logic out_ready [2];
    beat_t in_b [2];

    logic [CW-1:0] o_ctrl [2];
    logic [DW-1:0] o_pc4 [2];
    logic [DW-1:0] o_rs_val [2];
    logic [DW-1:0] o_rt_val [2];
    logic [DW-1:0] o_imm [2];
    logic [RW-1:0] o_rs [2];
    logic [RW-1:0] o_rt [2];
    logic [RW-1:0] o_rd [2];

    logic took [2];
    beat_t sbq [2][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(
        .DATA_W (DW), .RADDR_W (RW), .ALUOP_W (AW), .SKID (1)
    ) u0 (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid[0]), .in_ready (in_ready[0]),
        .in_ctrl (in_b[0].ctrl), .in_pc4 (in_b[0].pc4),
        .in_rs_val (in_b[0].rs_val), .in_rt_val (in_b[0].rt_val),
        .in_imm (in_b[0].imm), .in_rs (in_b[0].rs),
        .in_rt (in_b[0].rt), .in_rd (in_b[0].rd),
        .out_valid (out_valid[0]), .out_ready (out_ready[0]),
        .out_ctrl (o_ctrl[0]), .out_pc4 (o_pc4[0]),
        .out_rs_val (o_rs_val[0]), .out_rt_val (o_rt_val[0]),
        .out_imm (o_imm[0]), .out_rs (o_rs[0]),
        .out_rt (o_rt[0]), .out_rd (o_rd[0])
    );

    id_ex_stage_reg #(
        .DATA_W (DW), .RADDR_W (RW), .ALUOP_W (AW), .SKID (0)
    ) u1 (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid[1]), .in_ready (in_ready[1]),
        .in_ctrl (in_b[1].ctrl), .in_pc4 (in_b[1].pc4),
        .in_rs_val (in_b[1].rs_val), .in_rt_val (in_b[1].rt_val),
        .in_imm (in_b[1].imm), .in_rs (in_b[1].rs),
        .in_rt (in_b[1].rt), .in_rd (in_b[1].rd),
        .out_valid (out_valid[1]), .out_ready (out_ready[1]),
        .out_ctrl (o_ctrl[1]), .out_pc4 (o_pc4[1]),
        .out_rs_val (o_rs_val[1]), .out_rt_val (o_rt_val[1]),
        .out_imm (o_imm[1]), .out_rs (o_rs[1]),
        .out_rt (o_rt[1]), .out_rd (o_rd[1])
    );

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t rnd_beat();
        beat_t b;
        b.ctrl   = CW'($urandom);
        b.pc4    = {$urandom, $urandom};
        b.rs_val = {$urandom, $urandom};
        b.rt_val = {$urandom, $urandom};
        b.imm    = {$urandom, $urandom};
        b.rs     = RW'($urandom);
        b.rt     = RW'($urandom);
        b.rd     = RW'($urandom);
        return b;
    endfunction

    // Monitor: model occupancy and ordering, compare every out-transfer
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            beat_t ob;
            beat_t eb;
            logic  exp_rdy;
            took[k] = in_valid[k] && in_ready[k];
            if (rst) begin
                sbq[k].delete();
            end else begin
                chk($sformatf("u%0d out_valid", k), 512'(out_valid[k]),
                    512'(sbq[k].size() != 0));
                if (k == 0)
                    exp_rdy = sbq[k].size() < 2;
                else
                    exp_rdy = (sbq[k].size() == 0) || out_ready[k];
                chk($sformatf("u%0d in_ready", k), 512'(in_ready[k]),
                    512'(exp_rdy));
                if (!out_valid[k])
                    chk($sformatf("u%0d bubble_ctrl", k),
                        512'(o_ctrl[k] & KILL), 512'(0));
                if (flush) begin
                    sbq[k].delete();
                end else begin
                    if (out_valid[k] && out_ready[k] && sbq[k].size() != 0) begin
                        eb = sbq[k].pop_front();
                        ob = '{o_ctrl[k], o_pc4[k], o_rs_val[k], o_rt_val[k],
                               o_imm[k], o_rs[k], o_rt[k], o_rd[k]};
                        chk($sformatf("u%0d beat", k), 512'(ob), 512'(eb));
                    end
                    if (took[k])
                        sbq[k].push_back(in_b[k]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input beat_t b);
        in_b[0]     = b;
        in_valid[0] = 1'b1;
    endtask

    task automatic rand_drive(input int k, input int n);
        repeat (n) begin
            step();
            if (!in_valid[k] || took[k]) begin
                in_valid[k] = ($urandom % 4) != 0;
                in_b[k]     = rnd_beat();
            end
            out_ready[k] = ($urandom % 3) != 0;
        end
    endtask

    task automatic flush_drive(input int n);
        repeat (n) begin
            step();
            flush = ($urandom % 20) == 0;
        end
    endtask

    initial begin
        beat_t b;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            in_b[k]      = '0;
            took[k]      = 1'b0;
        end

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst out_valid", 512'(out_valid[0]), 512'(0));
        chk("rst in_ready", 512'(in_ready[0]), 512'(1));
        chk("rst fields", 512'({o_ctrl[0], o_pc4[0], o_rs_val[0],
            o_rt_val[0], o_imm[0], o_rs[0], o_rt[0], o_rd[0]}), 512'(0));

        // First beat appears one cycle later
        b = rnd_beat();
        b.pc4 = 64'h4;
        offer(b);
        step();
        in_valid[0] = 1'b0;
        chk("first out_valid", 512'(out_valid[0]), 512'(1));
        chk("first pc4", 512'(o_pc4[0]), 512'(64'h4));

        // Stream of 8 back-to-back beats
        for (int i = 0; i < 8; i++) begin
            offer(rnd_beat());
            step();
        end
        in_valid[0] = 1'b0;
        step();
        step();

        // Stall: A held, B into skid, C waits
        out_ready[0] = 1'b0;
        offer(rnd_beat());
        step();
        offer(rnd_beat());
        step();
        chk("skid full in_ready", 512'(in_ready[0]), 512'(0));
        offer(rnd_beat());
        step();
        out_ready[0] = 1'b1;
        step();
        step();
        in_valid[0] = 1'b0;
        repeat (3) step();

        // Flush with A held, B in skid, C offered
        out_ready[0] = 1'b0;
        b = rnd_beat();
        b.ctrl = '1;
        offer(b);
        step();
        b.pc4 = b.pc4 + 64'd4;
        offer(b);
        step();
        b.pc4 = b.pc4 + 64'd4;
        offer(b);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid[0] = 1'b0;
        chk("flush out_valid", 512'(out_valid[0]), 512'(0));
        chk("flush regwrite", 512'(o_ctrl[0][8]), 512'(0));
        chk("flush memwrite", 512'(o_ctrl[0][4]), 512'(0));
        out_ready[0] = 1'b1;
        repeat (3) step();

        // Idle gap with all control bits set on the input
        in_b[0].ctrl = '1;
        step();
        chk("gap out_valid", 512'(out_valid[0]), 512'(0));
        chk("gap killed ctrl", 512'(o_ctrl[0] & KILL), 512'(0));

        // Random traffic on both variants
        fork
            rand_drive(0, 3000);
            rand_drive(1, 3000);
            flush_drive(3000);
        join
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        repeat (5) step();
        for (int k = 0; k < 2; k++)
            chk($sformatf("u%0d drained", k), 512'(sbq[k].size()), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
